// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: register-mode encoding and
// serialiser FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register with six shift/rotate/load modes and an
// automatic LSB-first serialiser reporting busy, done and shift count.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    shift_cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);

    usr_mode_e        mode_s;
    usr_state_e       state_r;
    usr_state_e       state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             done_r;
    logic             done_next_s;
    logic             busy_r;

    assign mode_s = usr_mode_e'(mode);

    // Next-state logic: register-mode mux in IDLE, serial shift-out in SHIFT.
    always_comb begin
        q_next_s     = q_r;
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        done_next_s  = 1'b0;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        q_next_s     = d;
                        cnt_next_s   = ZERO_CNT;
                        state_next_s = SHIFT;
                    end else begin
                        case (mode_s)
                            MODE_HOLD: q_next_s = q_r;
                            MODE_LOAD: q_next_s = d;
                            MODE_SHL:  q_next_s = {q_r[WIDTH-2:0], sin_r};
                            MODE_SHR:  q_next_s = {sin_l, q_r[WIDTH-1:1]};
                            MODE_ROL:  q_next_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                            MODE_ROR:  q_next_s = {q_r[0], q_r[WIDTH-1:1]};
                            MODE_ASR:  q_next_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                            default:   q_next_s = q_r;
                        endcase
                    end
                end
                SHIFT: begin
                    q_next_s = {sin_l, q_r[WIDTH-1:1]};
                    if (cnt_r == LAST_CNT) begin
                        // Final bit leaves: count parks at WIDTH until next start.
                        cnt_next_s   = FULL_CNT;
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        cnt_next_s   = cnt_r + ONE_CNT;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // State registers; synchronous reset aborts any transfer without done.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r     <= RESET_VAL;
            state_r <= IDLE;
            cnt_r   <= ZERO_CNT;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            q_r     <= q_next_s;
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            done_r  <= done_next_s;
            busy_r  <= (state_next_s == SHIFT);
        end
    end

    assign q         = q_r;
    assign sout_lsb  = q_r[0];
    assign sout_msb  = q_r[WIDTH-1];
    assign busy      = busy_r;
    assign done      = done_r;
    assign shift_cnt = cnt_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8).
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             start;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_lsb;
    logic             sout_msb;
    logic             busy;
    logic             done;
    logic [CW-1:0]    shift_cnt;

    int n_vec;
    int n_err;
    int busy_cycles;
    logic [7:0] bits_exp;

    universal_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_lsb  (sout_lsb),
        .sout_msb  (sout_msb),
        .busy      (busy),
        .done      (done),
        .shift_cnt (shift_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_mode(input logic [2:0] m, input logic [7:0] load_val);
        mode = 3'b001; d = load_val; tick();
        mode = m; tick();
        mode = 3'b000;
    endtask

    initial begin
        n_vec = 0; n_err = 0; busy_cycles = 0;
        reset = 1'b1; en = 1'b1; start = 1'b1; d = 8'hFF;
        mode = 3'b000; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        reset = 1'b0; start = 1'b0;
        check("reset_q", 32'(q), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_cnt", 32'(shift_cnt), 32'h0);

        // Load then shift left with sin_r=1
        mode = 3'b001; d = 8'hA5; tick();
        check("load_a5", 32'(q), 32'hA5);
        mode = 3'b010; sin_r = 1'b1; tick();
        check("shl_4b", 32'(q), 32'h4B);
        check("shl_msb", 32'(sout_msb), 32'h0);
        mode = 3'b000; sin_r = 1'b0; tick();
        check("hold_4b", 32'(q), 32'h4B);
        mode = 3'b111; tick();
        check("rsvd_hold", 32'(q), 32'h4B);
        mode = 3'b001; d = 8'h11; en = 1'b0; tick();
        check("en0_hold", 32'(q), 32'h4B);
        en = 1'b1; mode = 3'b000;

        do_mode(3'b100, 8'h81);
        check("rol_81", 32'(q), 32'h03);
        do_mode(3'b101, 8'h81);
        check("ror_81", 32'(q), 32'hC0);
        sin_l = 1'b0;
        do_mode(3'b110, 8'h80);
        check("asr_80", 32'(q), 32'hC0);
        do_mode(3'b011, 8'h80);
        check("shr_80", 32'(q), 32'h40);
        check("mode_cnt", 32'(shift_cnt), 32'h0);

        // en=0 with start in IDLE must not latch
        en = 1'b0; start = 1'b1; d = 8'h33; tick();
        start = 1'b0; en = 1'b1; tick();
        check("idle_en0_start", 32'(busy), 32'h0);

        // Serialise B4; stray start mid-transfer is ignored
        bits_exp = 8'b1011_0100;
        d = 8'hB4; start = 1'b1; mode = 3'b001; tick();
        start = 1'b0; mode = 3'b000;
        for (int k = 0; k < 8; k++) begin
            check("b4_bit", 32'(sout_lsb), 32'(bits_exp[k]));
            check("b4_cnt", 32'(shift_cnt), 32'(k));
            check("b4_busy", 32'(busy), 32'h1);
            check("b4_done", 32'(done), 32'h0);
            if (k == 3) begin
                start = 1'b1; d = 8'hFF;
            end
            tick();
            start = 1'b0;
        end
        check("b4_end_busy", 32'(busy), 32'h0);
        check("b4_end_done", 32'(done), 32'h1);
        check("b4_end_cnt", 32'(shift_cnt), 32'h8);
        check("b4_end_q", 32'(q), 32'h00);
        tick();
        check("b4_done_drop", 32'(done), 32'h0);
        check("b4_cnt_park", 32'(shift_cnt), 32'h8);

        // Serialise 0F with a 3-cycle pause at bit 2
        bits_exp = 8'b0000_1111;
        d = 8'h0F; start = 1'b1; tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy) busy_cycles++;
            check("0f_bit", 32'(sout_lsb), 32'(bits_exp[k]));
            if (k == 2) begin
                for (int p = 0; p < 3; p++) begin
                    en = 1'b0; tick();
                    if (busy) busy_cycles++;
                    check("0f_pause_cnt", 32'(shift_cnt), 32'h2);
                    check("0f_pause_q", 32'(q), 32'h03);
                    check("0f_pause_busy", 32'(busy), 32'h1);
                end
                en = 1'b1;
            end
            tick();
        end
        check("0f_busy_cycles", 32'(busy_cycles), 32'd11);
        check("0f_done", 32'(done), 32'h1);
        check("0f_cnt", 32'(shift_cnt), 32'h8);

        // Reset aborts a transfer at shift_cnt=4
        d = 8'h5A; start = 1'b1; tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("abort_cnt4", 32'(shift_cnt), 32'h4);
        reset = 1'b1; tick();
        reset = 1'b0;
        check("abort_q", 32'(q), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_cnt", 32'(shift_cnt), 32'h0);
        tick();
        check("abort_done_after", 32'(done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with synchronous reset, clock enable, six register modes and an automatic serialiser.
- The serialiser loads a word, then shifts it out LSB-first with busy/done status.
- It is the general-purpose storage, shift and serialise element for datapath and serial-link blocks.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; overrides every other input.
- en  input  1  clock enable; when low, all state holds, including the serialiser.
- mode  input  3  register operation, applied only in IDLE (encoding below).
- start  input  1  begins auto-serialise of d; sampled only in IDLE with en=1.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial fill bit entering the MSB on right shifts.
- sin_r  input  1  serial fill bit entering the LSB on left shifts.
- q  output  WIDTH  register contents.
- sout_lsb  output  1  q[0], driven combinationally from the register.
- sout_msb  output  1  q[WIDTH-1], driven combinationally from the register.
- busy  output  1  high while the FSM is in SHIFT.
- done  output  1  one-cycle pulse after the last serial bit.
- shift_cnt  output  CW=$clog2(WIDTH+1)  number of serial shifts completed.

Behaviour:
- Reset (reset=1 at a clock edge):
  - q <= RESET_VAL, FSM <= IDLE, shift_cnt <= 0, done <= 0, busy = 0.
  - Reset overrides en, start and mode.
  - Reset during SHIFT aborts the transfer; done is not pulsed.
- Latency: every update takes effect at the rising edge after the inputs are sampled (1 cycle). All outputs are registered except sout_lsb and sout_msb, which are wires from q.
- mode encoding (IDLE, en=1, start=0):
  - 000: hold.
  - 001: q <= d.
  - 010: shift left, q <= {q[WIDTH-2:0], sin_r}.
  - 011: shift right, q <= {sin_l, q[WIDTH-1:1]}.
  - 100: rotate left.
  - 101: rotate right.
  - 110: arithmetic shift right; MSB is replicated and sin_l is ignored.
  - 111: reserved, behaves as hold.
- FSM states: IDLE and SHIFT. busy = (state == SHIFT).
- IDLE to SHIFT: on en=1 and start=1, q <= d and shift_cnt <= 0.
  - start takes priority over mode; mode is ignored on that edge.
  - While in SHIFT, sout_lsb shows the current serial bit. Bit k is visible while shift_cnt == k.
- In SHIFT with en=1:
  - q <= {sin_l, q[WIDTH-1:1]} and shift_cnt increments.
  - If shift_cnt == WIDTH-1 on that edge: state <= IDLE, shift_cnt <= WIDTH, and done <= 1 for exactly one cycle.
- In SHIFT with en=0: q, shift_cnt and state hold (pause). busy stays high.
- start and mode are ignored while busy. start while already in SHIFT does not restart the transfer.
- done is 0 in every cycle except the single cycle after the final shift.
- shift_cnt holds its value (WIDTH after a completed transfer) until the next start or reset. Register modes in IDLE do not change it.
- en=0 in IDLE: everything holds; start is not latched.

Decomposition:
- Package usr_pkg holds:
  - Typedef usr_mode_e (3-bit enum MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_RSVD).
  - Typedef usr_state_e (IDLE, SHIFT).
- Single module; no sub-module is warranted. The next-q mux and the FSM live in one always block plus combinational next-state logic.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
- reset=1 for 1 cycle with d=8'hFF, start=1 -> q=8'h00, busy=0, done=0, shift_cnt=0.
- mode=LOAD, d=8'hA5, then mode=SHL, sin_r=1 for 1 cycle -> q=8'hA5, then 8'h4B.
- q=8'h81: ROL -> 8'h03; ROR from 8'h81 -> 8'hC0; ASR from 8'h80 -> 8'hC0; SHR, sin_l=0 from 8'h80 -> 8'h40.
- start=1, d=8'hB4 with en held high -> sout_lsb sequence 0,0,1,0,1,1,0,1 over 8 cycles, busy high for 8 cycles, done high for the 1 cycle after, shift_cnt=8; a start pulse mid-transfer has no effect.
- Serialise 8'h0F with en=0 for 3 cycles mid-transfer -> q and shift_cnt freeze; total busy duration is 11 cycles; the output bit order is unchanged.
- reset=1 at shift_cnt=4 during a serialise -> next cycle q=8'h00, busy=0, done stays 0, shift_cnt=0.
